nyq_interp: RTL and testbench

NYQ_INTERP -- requirements
Module: nyq_interp

---
 rtl/nyq_interp.sv | 140 ++++++++++++++
 tb/tb_nyq_interp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nyq_interp.sv
// nyq_interp: 32-tap, 4-phase polyphase interpolator (x4 upsample + low-pass) built around one shared MAC.
// Build option NYQI_SAT_EN: clip the output to the OUT_WIDTH range instead of two's-complement wrap.
module nyq_interp #(
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_WIDTH  = 32,
   parameter int IN_WIDTH   = 24,
   parameter int OUT_WIDTH  = 24
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   input  logic                  WrEn_SI,
   input  logic [ADDR_WIDTH-1:0] Addr_DI,
   input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
   input  logic [IN_WIDTH-1:0]   NYQI_In_DI,
   input  logic                  NYQI_InValid_SI,
   output logic                  NYQI_InReady_SO,
   output logic [OUT_WIDTH-1:0]  NYQI_Out_DO,
   output logic                  NYQI_OutValid_SO
);

   localparam int COEF_W = 24;
   localparam int PROD_W = COEF_W + IN_WIDTH;
   localparam int ACC_W  = PROD_W + 3;
   localparam int SHIFT  = 23;
   localparam int DEPTH  = 2**ADDR_WIDTH;

   typedef enum logic {IDLE, MAC} state_t;

   state_t                     state_q, state_d;
   logic [2:0]                 tap_q;
   logic [1:0]                 phase_q;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [IN_WIDTH-1:0] x_q [0:7];
   logic [COEF_W-1:0]          coef_q [0:DEPTH-1];
   logic [OUT_WIDTH-1:0]       out_q;
   logic                       out_valid_q;

   logic [ADDR_WIDTH-1:0]      coef_addr;
   logic signed [COEF_W-1:0]   coef_rd;
   logic signed [PROD_W-1:0]   product;
   logic signed [ACC_W-1:0]    sum_d;
   logic [OUT_WIDTH-1:0]       result_d;
   logic                       unused_par_bits;

   // Tap j of phase p lives at address 4*j+p, so the address is just {tap, phase}.
   assign coef_addr = ADDR_WIDTH'({tap_q, phase_q});
   assign coef_rd   = coef_q[coef_addr];
   assign product   = coef_rd * x_q[tap_q];
   assign sum_d     = acc_q + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

   assign unused_par_bits = ^PAR_In_DI[MEM_WIDTH-1:COEF_W];

`ifdef NYQI_SAT_EN
   localparam int SH_W = ACC_W - SHIFT;
   localparam logic signed [SH_W-1:0] OUT_MAX = {{(SH_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [SH_W-1:0] OUT_MIN = {{(SH_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [SH_W-1:0] shifted;
   assign shifted = SH_W'(sum_d >>> SHIFT);

   always_comb begin
      result_d = shifted[OUT_WIDTH-1:0];
      if (shifted > OUT_MAX) begin
         result_d = OUT_MAX[OUT_WIDTH-1:0];
      end else if (shifted < OUT_MIN) begin
         result_d = OUT_MIN[OUT_WIDTH-1:0];
      end
   end
`else
   assign result_d = OUT_WIDTH'(sum_d >>> SHIFT);
`endif

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (NYQI_InValid_SI) state_d = MAC;
         MAC:  if (tap_q == 3'd7 && phase_q == 2'd3) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reads are combinational from the register array, so a same-edge write is seen one edge later.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         for (int k = 0; k < DEPTH; k++) coef_q[k] <= '0;
      end else if (WrEn_SI) begin
         coef_q[Addr_DI] <= PAR_In_DI[COEF_W-1:0];
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         tap_q       <= '0;
         phase_q     <= '0;
         acc_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         for (int k = 0; k < 8; k++) x_q[k] <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (NYQI_InValid_SI) begin
                  x_q[0] <= NYQI_In_DI;
                  for (int k = 1; k < 8; k++) x_q[k] <= x_q[k-1];
                  acc_q   <= '0;
                  tap_q   <= '0;
                  phase_q <= '0;
               end
            end
            MAC: begin
               if (tap_q == 3'd7) begin
                  out_q       <= result_d;
                  out_valid_q <= 1'b1;
                  acc_q       <= '0;
                  tap_q       <= '0;
                  phase_q     <= phase_q + 2'd1;
               end else begin
                  acc_q <= sum_d;
                  tap_q <= tap_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign NYQI_InReady_SO  = (state_q == IDLE);
   assign NYQI_Out_DO      = out_q;
   assign NYQI_OutValid_SO = out_valid_q;

endmodule

// File: tb/tb_nyq_interp.sv
// Self-checking bench for nyq_interp: random and directed samples against a plain-arithmetic polyphase model.
module tb_nyq_interp;

   localparam int AW = 5;
   localparam int MW = 32;
   localparam int IW = 24;
   localparam int OW = 24;

   logic          Clk_CI = 1'b0;
   logic          Rst_RBI = 1'b0;
   logic          WrEn_SI = 1'b0;
   logic [AW-1:0] Addr_DI = '0;
   logic [MW-1:0] PAR_In_DI = '0;
   logic [IW-1:0] NYQI_In_DI = '0;
   logic          NYQI_InValid_SI = 1'b0;
   logic          NYQI_InReady_SO;
   logic [OW-1:0] NYQI_Out_DO;
   logic          NYQI_OutValid_SO;

   int errors = 0;
   int checks = 0;
   int cycle_cnt = 0;
   int pulse_cnt = 0;
   int hm [32];
   int xm [8];

   nyq_interp #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .Clk_CI(Clk_CI),
      .Rst_RBI(Rst_RBI),
      .WrEn_SI(WrEn_SI),
      .Addr_DI(Addr_DI),
      .PAR_In_DI(PAR_In_DI),
      .NYQI_In_DI(NYQI_In_DI),
      .NYQI_InValid_SI(NYQI_InValid_SI),
      .NYQI_InReady_SO(NYQI_InReady_SO),
      .NYQI_Out_DO(NYQI_Out_DO),
      .NYQI_OutValid_SO(NYQI_OutValid_SO)
   );

   always #5 Clk_CI = ~Clk_CI;

   always @(posedge Clk_CI) cycle_cnt++;

   always @(negedge Clk_CI) if (NYQI_OutValid_SO === 1'b1) pulse_cnt++;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int sx24(input logic [23:0] v);
      return {{8{v[23]}}, v};
   endfunction

   // y[4n+p] = floor(sum_j h[4j+p]*x[n-j] / 2^23), then wrapped or clipped to 24 bits.
   function automatic logic [23:0] modelOut(input int p);
      longint acc;
      longint sh;
      acc = 0;
      for (int j = 0; j < 8; j++) acc += longint'(hm[4*j+p]) * longint'(xm[j]);
      sh = acc >>> 23;
`ifdef NYQI_SAT_EN
      if (sh > 64'sd8388607) sh = 64'sd8388607;
      else if (sh < -64'sd8388608) sh = -64'sd8388608;
`endif
      return sh[23:0];
   endfunction

   task automatic clearModel();
      for (int k = 0; k < 32; k++) hm[k] = 0;
      for (int k = 0; k < 8; k++) xm[k] = 0;
   endtask

   task automatic resetDut();
      @(negedge Clk_CI);
      Rst_RBI = 1'b0;
      WrEn_SI = 1'b0;
      NYQI_InValid_SI = 1'b0;
      clearModel();
      @(negedge Clk_CI);
      @(negedge Clk_CI);
      Rst_RBI = 1'b1;
   endtask

   task automatic writeCoef(input int k, input logic [31:0] v);
      @(negedge Clk_CI);
      WrEn_SI = 1'b1;
      Addr_DI = AW'(k);
      PAR_In_DI = v;
      @(posedge Clk_CI);
      #1;
      WrEn_SI = 1'b0;
      hm[k] = sx24(v[23:0]);
   endtask

   // Sends one sample, then checks the four phase outputs, their timing and the handshake.
   task automatic applyStimulus(input logic [23:0] x, input bit hold, input string tag,
                                output int acc_cycle, output logic [3:0][23:0] outs);
      int waited;
      bit early;
      logic [23:0] prev;
      waited = 0;
      outs = '0;
      acc_cycle = 0;
      while (NYQI_InReady_SO !== 1'b1 && waited < 100) begin
         @(posedge Clk_CI);
         #1;
         waited++;
      end
      if (NYQI_InReady_SO !== 1'b1) begin
         checkOutput($sformatf("%s_ready_timeout", tag), 32'(NYQI_InReady_SO), 32'd1);
         return;
      end
      @(negedge Clk_CI);
      NYQI_In_DI = x;
      NYQI_InValid_SI = 1'b1;
      @(posedge Clk_CI);
      #1;
      acc_cycle = cycle_cnt;
      if (!hold) NYQI_InValid_SI = 1'b0;
      for (int j = 7; j > 0; j--) xm[j] = xm[j-1];
      xm[0] = sx24(x);
      checkOutput($sformatf("%s_ready_busy", tag), 32'(NYQI_InReady_SO), 32'd0);
      for (int p = 0; p < 4; p++) begin
         early = 1'b0;
         prev = NYQI_Out_DO;
         for (int i = 0; i < 7; i++) begin
            @(posedge Clk_CI);
            #1;
            if (NYQI_OutValid_SO !== 1'b0 || NYQI_Out_DO !== prev) early = 1'b1;
         end
         checkOutput($sformatf("%s_p%0d_quiet", tag, p), 32'(early), 32'd0);
         @(posedge Clk_CI);
         #1;
         outs[p] = NYQI_Out_DO;
         checkOutput($sformatf("%s_p%0d_valid", tag, p), 32'(NYQI_OutValid_SO), 32'd1);
         checkOutput($sformatf("%s_p%0d_out", tag, p), 32'(NYQI_Out_DO), 32'(modelOut(p)));
      end
      checkOutput($sformatf("%s_ready_done", tag), 32'(NYQI_InReady_SO), 32'd1);
   endtask

   task automatic impulseRun(input string tag);
      int c;
      logic [3:0][23:0] o;
      for (int n = 0; n < 8; n++) begin
         applyStimulus((n == 0) ? 24'h400000 : 24'h000000, 1'b0, $sformatf("%s_n%0d", tag, n), c, o);
         for (int p = 0; p < 4; p++)
            checkOutput($sformatf("%s_n%0d_p%0d_const", tag, n, p), 32'(o[p]), 32'(4*n + p + 1));
      end
   endtask

   initial begin
      int c0, c1;
      int snap;
      logic [3:0][23:0] o;

      clearModel();
      #2;
      checkOutput("rst_out", 32'(NYQI_Out_DO), 32'd0);
      checkOutput("rst_valid", 32'(NYQI_OutValid_SO), 32'd0);
      checkOutput("rst_ready", 32'(NYQI_InReady_SO), 32'd1);
      resetDut();

      for (int k = 0; k < 32; k++) writeCoef(k, 32'(2*(k+1)));
      impulseRun("imp");

      // Coefficients rewritten in IDLE between samples, with junk in the ignored upper bits.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 32; k++) writeCoef(k, $urandom);
         for (int s = 0; s < 6; s++)
            applyStimulus(24'($urandom), 1'b0, $sformatf("rnd%0d_%0d", r, s), c0, o);
      end

      applyStimulus(24'($urandom), 1'b1, "hs0", c0, o);
      for (int s = 1; s < 4; s++) begin
         applyStimulus(24'($urandom), 1'b1, $sformatf("hs%0d", s), c1, o);
         checkOutput($sformatf("hs%0d_spacing", s), 32'(c1 - c0), 32'd33);
         c0 = c1;
      end
      NYQI_InValid_SI = 1'b0;

      resetDut();
      writeCoef(0, 32'h007FFFFF);
      applyStimulus(24'h800000, 1'b0, "sign", c0, o);
      checkOutput("sign_p0_const", 32'(o[0]), 32'h00800001);
      for (int p = 1; p < 4; p++) checkOutput($sformatf("sign_p%0d_const", p), 32'(o[p]), 32'd0);

      resetDut();
      for (int k = 0; k < 32; k++) writeCoef(k, 32'h007FFFFF);
      for (int n = 0; n < 8; n++) applyStimulus(24'h7FFFFF, 1'b0, $sformatf("ovf%0d", n), c0, o);
`ifdef NYQI_SAT_EN
      checkOutput("ovf_last_const", 32'(o[3]), 32'h007FFFFF);
`else
      checkOutput("ovf_last_const", 32'(o[3]), 32'h00FFFFF0);
`endif

      // Abort a sample in phase 2 with an asynchronous reset between clock edges.
      @(negedge Clk_CI);
      NYQI_In_DI = 24'h123456;
      NYQI_InValid_SI = 1'b1;
      @(posedge Clk_CI);
      #1;
      NYQI_InValid_SI = 1'b0;
      repeat (18) @(posedge Clk_CI);
      #3;
      Rst_RBI = 1'b0;
      clearModel();
      #1;
      checkOutput("abort_out", 32'(NYQI_Out_DO), 32'd0);
      checkOutput("abort_valid", 32'(NYQI_OutValid_SO), 32'd0);
      checkOutput("abort_ready", 32'(NYQI_InReady_SO), 32'd1);
      snap = pulse_cnt;
      @(negedge Clk_CI);
      Rst_RBI = 1'b1;
      repeat (40) @(posedge Clk_CI);
      #1;
      checkOutput("abort_no_pulse", 32'(pulse_cnt - snap), 32'd0);

      for (int n = 0; n < 8; n++)
         applyStimulus((n == 0) ? 24'h400000 : 24'h000000, 1'b0, $sformatf("zc%0d", n), c0, o);
      checkOutput("zc_cleared_coef", 32'(o[3]), 32'd0);
      for (int k = 0; k < 32; k++) writeCoef(k, 32'(2*(k+1)));
      impulseRun("imp2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
